// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM encoding and EX/MEM layout.
package ex_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [1:0]  mem;
    logic        wb;
  } exmem_t;

  // A bubble is an all-zero EX/MEM entry: no register write, no memory access.
  localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative multiplier retiring K multiplier bits per cycle; product is the low 32 bits.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int K = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        busy,
  output logic        last,
  output logic [31:0] product
);

  localparam int N  = 32 / K;
  localparam int CW = $clog2(N);

  logic [31:0]   mcand;
  logic [31:0]   mplier;
  logic [31:0]   partial;
  logic [31:0]   step;
  logic [CW-1:0] count;

  // The multiplicand is pre-shifted by K each iteration, which equals shifting
  // each partial term by K*count.
  always_comb begin
    step = mcand * {{(32-K){1'b0}}, mplier[K-1:0]};
  end

  assign product = partial + step;
  assign last    = busy && (count == CW'(N - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      count   <= '0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      partial <= '0;
      count   <= '0;
    end else if (busy) begin
      mcand   <= mcand << K;
      mplier  <= mplier >> K;
      partial <= product;
      count   <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops, iterative mul with pipeline stall, EX/MEM register.
// Optional: define EX_STALL_CNT_EN to add the saturating stall-cycle counter mul_stall_cnt_o.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] val1_i,
  input  logic [31:0] val2_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  alu_ctrl_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  mem_i,
  input  logic        wb_i,
  output logic        stall_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  mem_o,
  output logic        wb_o
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0] mul_stall_cnt_o
`endif
);

  ex_state_e   state, state_next;
  logic        is_mul;
  logic        mul_start;
  logic        mul_last;
  logic [31:0] mul_product;
  logic [31:0] alu_res;
  exmem_t      exmem_next, exmem_q;

  assign is_mul = (alu_ctrl_i == ALU_MUL);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (is_mul)   state_next = BUSY;
      BUSY: if (mul_last) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Stall covers the presentation cycle and every BUSY cycle except the last.
  always_comb begin
    mul_start = 1'b0;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        mul_start = is_mul;
        stall_o   = is_mul && rst_i;
      end
      BUSY:    stall_o = !mul_last && rst_i;
      default: stall_o = 1'b0;
    endcase
  end

  ex_mul_iter #(
    .K(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (mul_start),
    .a      (val1_i),
    .b      (val2_i),
    .busy   (state == BUSY),
    .last   (mul_last),
    .product(mul_product)
  );

  always_comb begin
    case (alu_ctrl_i)
      ALU_ADD: alu_res = val1_i + val2_i;
      ALU_SUB: alu_res = val1_i - val2_i;
      ALU_AND: alu_res = val1_i & val2_i;
      ALU_OR:  alu_res = val1_i | val2_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    exmem_next = '{alu_result: alu_res, store_data: store_data_i,
                   rd_addr: rd_addr_i, mem: mem_i, wb: wb_i};
    if (state == BUSY) begin
      if (mul_last) exmem_next.alu_result = mul_product;
      else          exmem_next = EXMEM_BUBBLE;
    end else if (is_mul) begin
      exmem_next = EXMEM_BUBBLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) exmem_q <= EXMEM_BUBBLE;
    else        exmem_q <= exmem_next;
  end

  assign alu_result_o = exmem_q.alu_result;
  assign store_data_o = exmem_q.store_data;
  assign rd_addr_o    = exmem_q.rd_addr;
  assign mem_o        = exmem_q.mem;
  assign wb_o         = exmem_q.wb;

`ifdef EX_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i)                                  mul_stall_cnt_o <= '0;
    else if (stall_o && (mul_stall_cnt_o != '1)) mul_stall_cnt_o <= mul_stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven ALU vectors plus mul/reset sequences,
// with a queue scoreboard of expected EX/MEM contents (default and 4-bits-per-cycle builds).
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [1:0]  mem;
    logic        wb;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [1:0]  mem;
    logic        wb;
    logic [31:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] val1, val2, sd_in;
  logic [3:0]  ctrl;
  logic [4:0]  rd_in;
  logic [1:0]  mem_in;
  logic        wb_in;
  logic        use4;

  logic        stall1, stall4, wb1, wb4;
  logic [31:0] res1, res4, sd1, sd4;
  logic [4:0]  rd1, rd4;
  logic [1:0]  mem1, mem4;
`ifdef EX_STALL_CNT_EN
  logic [31:0] scnt1, scnt4;
`endif

  logic stall_sel;
  exp_t got;
  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign stall_sel = use4 ? stall4 : stall1;
  assign got = use4 ? {res4, sd4, rd4, mem4, wb4} : {res1, sd1, rd1, mem1, wb1};

  ex_stage dut (
    .clk_i(clk), .rst_i(rst_n), .val1_i(val1), .val2_i(val2), .store_data_i(sd_in),
    .alu_ctrl_i(ctrl), .rd_addr_i(rd_in), .mem_i(mem_in), .wb_i(wb_in),
    .stall_o(stall1), .alu_result_o(res1), .store_data_o(sd1), .rd_addr_o(rd1),
    .mem_o(mem1), .wb_o(wb1)
`ifdef EX_STALL_CNT_EN
    , .mul_stall_cnt_o(scnt1)
`endif
  );

  ex_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .val1_i(val1), .val2_i(val2), .store_data_i(sd_in),
    .alu_ctrl_i(ctrl), .rd_addr_i(rd_in), .mem_i(mem_in), .wb_i(wb_in),
    .stall_o(stall4), .alu_result_o(res4), .store_data_o(sd4), .rd_addr_o(rd4),
    .mem_o(mem4), .wb_o(wb4)
`ifdef EX_STALL_CNT_EN
    , .mul_stall_cnt_o(scnt4)
`endif
  );

  task automatic checkOutput(input string name);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got res=%h", name, got.res);
      return;
    end
    e = expq.pop_front();
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s: got res=%h sd=%h rd=%0d mem=%b wb=%b, expected res=%h sd=%h rd=%0d mem=%b wb=%b",
               name, got.res, got.sd, got.rd, got.mem, got.wb, e.res, e.sd, e.rd, e.mem, e.wb);
    end
  endtask

  // One cycle: drive inputs, check combinational stall, queue the expected EX/MEM, compare after the edge.
  task automatic applyStimulus(input string name, input logic r, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] s, input logic [3:0] c,
                               input logic [4:0] d, input logic [1:0] m, input logic w,
                               input logic exp_stall, input exp_t e);
    @(negedge clk);
    rst_n = r; val1 = a; val2 = b; sd_in = s; ctrl = c; rd_in = d; mem_in = m; wb_in = w;
    #1;
    checks++;
    if (stall_sel !== exp_stall) begin
      errors++;
      $display("[TB] FAIL %s stall: got %b, expected %b", name, stall_sel, exp_stall);
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  // Full multiply: presentation cycle plus n iterations; stall high for exactly n cycles.
  task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic [4:0] d, input logic [1:0] m,
                        input logic w, input int n, input logic [31:0] prod);
    for (int i = 0; i <= n; i++) begin
      if (i < n) applyStimulus(name, 1'b1, a, b, s, 4'b1111, d, m, w, 1'b1, '0);
      else       applyStimulus(name, 1'b1, a, b, s, 4'b1111, d, m, w, 1'b0, {prod, s, d, m, w});
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] ra, rb, rp;

    vecs[0] = '{"add",      32'd7,          32'hFFFFFFFF, 32'h0,        4'b0010, 5'd5,  2'b00, 1'b1, 32'd6};
    vecs[1] = '{"sub",      32'd5,          32'd9,        32'h0,        4'b0110, 5'd6,  2'b00, 1'b1, 32'hFFFFFFFC};
    vecs[2] = '{"and",      32'h0000F0F0,   32'h00000FF0, 32'h0,        4'b0000, 5'd7,  2'b00, 1'b1, 32'h000000F0};
    vecs[3] = '{"or",       32'h0000F000,   32'h0000000F, 32'h0,        4'b0001, 5'd8,  2'b00, 1'b1, 32'h0000F00F};
    vecs[4] = '{"unknown",  32'h12345678,   32'h1,        32'hCAFEF00D, 4'b0101, 5'd9,  2'b10, 1'b1, 32'h0};
    vecs[5] = '{"add_wrap", 32'h80000000,   32'h80000001, 32'h0,        4'b0010, 5'd31, 2'b00, 1'b1, 32'h1};
    vecs[6] = '{"store",    32'h00001000,   32'h00000010, 32'hDEADBEEF, 4'b0010, 5'd0,  2'b01, 1'b0, 32'h00001010};
    vecs[7] = '{"sub_zero", 32'h0,          32'h1,        32'h0,        4'b0110, 5'd12, 2'b00, 1'b1, 32'hFFFFFFFF};

    use4 = 1'b0;
    rst_n = 1'b0; val1 = '0; val2 = '0; sd_in = '0; ctrl = '0; rd_in = '0; mem_in = '0; wb_in = 1'b0;

    for (int i = 0; i < 3; i++)
      applyStimulus("reset_hold", 1'b0, 32'h00010003, 32'h00020005, 32'h0, 4'b1111,
                    5'd3, 2'b00, 1'b1, 1'b0, '0);

    runMul("mul_k1", 32'h00010003, 32'h00020005, 32'h0, 5'd3, 2'b00, 1'b1, 32, 32'h000B000F);

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].name, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].ctrl,
                    vecs[i].rd, vecs[i].mem, vecs[i].wb, 1'b0,
                    {vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].mem, vecs[i].wb});

    ra = $urandom; rb = $urandom; rp = ra * rb;
    runMul("mul_rand", ra, rb, 32'h55AA55AA, 5'd17, 2'b00, 1'b1, 32, rp);

    // Abandon a multiply at BUSY count 10, then prove the stage is back in IDLE.
    for (int i = 0; i <= 10; i++)
      applyStimulus("mul_abort", 1'b1, 32'd6, 32'd7, 32'h0, 4'b1111, 5'd4, 2'b00, 1'b1, 1'b1, '0);
    applyStimulus("abort_reset", 1'b0, 32'd6, 32'd7, 32'h0, 4'b1111, 5'd4, 2'b00, 1'b1, 1'b0, '0);
    applyStimulus("after_abort", 1'b1, 32'd20, 32'd22, 32'h0, 4'b0010, 5'd10, 2'b00, 1'b1, 1'b0,
                  {32'd42, 32'h0, 5'd10, 2'b00, 1'b1});
    applyStimulus("after_abort2", 1'b1, 32'd1, 32'd1, 32'h0, 4'b0001, 5'd11, 2'b00, 1'b1, 1'b0,
                  {32'd1, 32'h0, 5'd11, 2'b00, 1'b1});

    use4 = 1'b1;
    applyStimulus("k4_reset", 1'b0, 32'h0, 32'h0, 32'h0, 4'b0010, 5'd0, 2'b00, 1'b0, 1'b0, '0);
    runMul("mul_k4_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd3, 2'b00, 1'b1, 8, 32'h00000001);
    runMul("mul_k4_b2b", 32'd3, 32'd4, 32'h0, 5'd14, 2'b00, 1'b1, 8, 32'd12);
    applyStimulus("k4_add", 1'b1, 32'd100, 32'd1, 32'h0, 4'b0010, 5'd2, 2'b00, 1'b1, 1'b0,
                  {32'd101, 32'h0, 5'd2, 2'b00, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline, directly downstream of the ID/EX register.
- Consumes ID/EX outputs (operands, 4-bit ALU control, rd, Mem/WB control) and computes add/sub/and/or in one cycle.
- Computes mul with an iterative multiplier.
- Registers results into the EX/MEM pipeline register and raises a stall to freeze IF/ID and ID/EX while a multiply is in flight.

Parameters:
- MUL_BITS_PER_CYCLE, 1: multiplier bits retired per iteration; legal values 1, 2, 4, 8. Multiply iterations N = 32/MUL_BITS_PER_CYCLE.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-low reset.
- val1_i  in  32  operand A from ID/EX.
- val2_i  in  32  operand B from ID/EX (already immediate-muxed).
- store_data_i  in  32  rs2 value for stores.
- alu_ctrl_i  in  4  0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul.
- rd_addr_i  in  5  destination register.
- mem_i  in  2  Mem control {MemRead, MemWrite}.
- wb_i  in  1  RegWrite.
- stall_o  out  1  hold IF/ID and ID/EX; combinational.
- alu_result_o  out  32  EX/MEM result.
- store_data_o  out  32  EX/MEM store data.
- rd_addr_o  out  5  EX/MEM rd.
- mem_o  out  2  EX/MEM Mem control.
- wb_o  out  1  EX/MEM RegWrite.

Behaviour:
- Reset: rst_i low at posedge clears every registered output to 0 and sets state IDLE. stall_o is forced 0 while rst_i is low. Reset during BUSY abandons the multiply.
- States: IDLE, BUSY. Iteration counter is log2(N) bits wide. Internal registers: multiplicand, multiplier, partial product.
- IDLE, non-mul op: result computed with 32-bit wrap-around arithmetic. All EX/MEM outputs load at the next edge (latency 1). stall_o = 0.
- Unknown alu_ctrl: alu_result_o = 0; control fields still pass through.
- IDLE, alu_ctrl_i = 1111:
  - stall_o = 1 in the same cycle.
  - Next edge: capture operands, clear the partial product, set count = 0, go to BUSY.
  - EX/MEM loads a bubble: wb_o = 0, mem_o = 0, rd_addr_o = 0, result = 0.
- BUSY, each cycle: partial product += (multiplicand × low K multiplier bits) << (K·count), K = MUL_BITS_PER_CYCLE. Multiplier shifts right by K; count increments.
  - count < N-1: stall_o = 1; EX/MEM loads a bubble each edge.
  - count = N-1 (final iteration): stall_o = 0. EX/MEM loads the low 32 bits of the product including the final step, plus rd/mem/wb/store_data from the (held) inputs. Go to IDLE.
- Multiply latency: N+1 cycles from mul presentation to result on EX/MEM. Stall width is exactly N cycles (N=32 at default).
- Product is the low 32 bits only; signed and unsigned results are identical.
- Inputs are held stable by upstream while stall_o = 1. The block uses captured operands, and uses live inputs only for the EX/MEM control fields on the final cycle.
- Back-to-back muls: the second mul is presented in the cycle after completion and starts a fresh IDLE→BUSY sequence. There are no dead cycles beyond the bubbles.
- The block performs no forwarding and no flush handling.

Optional Feature:
- EX_STALL_CNT_EN defined: adds output mul_stall_cnt_o [31:0]. It is a saturating count of cycles with stall_o = 1, cleared by reset, and holds at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ex_pkg holds:
  - ALU control localparams ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_MUL = 4'b1111.
  - State encoding for IDLE/BUSY.
  - The bubble constant for EX/MEM fields.
- Sub-module ex_mul_iter is natural:
  - Contains the operand capture registers, counter and partial-product datapath.
  - Ports: start, a, b, busy, last, product.
  - ex_stage owns the FSM-level stall and the EX/MEM register.

Test Plan:
- Reset: hold rst_i low 3 cycles with mul presented → all outputs 0, stall_o = 0. Release → mul starts next edge.
- add: val1 = 7, val2 = 0xFFFFFFFF, alu_ctrl = 0010, rd = 5, wb = 1 → after 1 edge alu_result_o = 6, rd_addr_o = 5, wb_o = 1, stall_o never 1.
- sub/and/or:
  - 5−9 → 0xFFFFFFFC.
  - 0xF0F0 & 0x0FF0 → 0x00F0.
  - 0xF000 | 0x000F → 0xF00F.
- mul, default parameter: 0x00010003 × 0x00020005, rd = 3 → stall_o high exactly 32 cycles. 32 bubbles (wb_o = 0) appear. Result 0x000B000F with wb_o = 1 on edge 33.
- mul, MUL_BITS_PER_CYCLE = 4: 0xFFFFFFFF × 0xFFFFFFFF → stall 8 cycles, result 0x00000001. Back-to-back second mul 3 × 4 → 12 after another 8 cycles of stall.
- Reset mid-mul: assert rst_i at BUSY count 10 → next edge state IDLE, outputs 0, stall_o = 0. No result is ever written.
